// File: rtl/sys_debug_pkg.sv
// Shared constants, FSM state type and sizing helper for the debug host controller.
package sys_debug_pkg;

  localparam logic [7:0] OP_RST  = 8'h52;
  localparam logic [7:0] OP_LOAD = 8'h4C;
  localparam logic [7:0] OP_SEL  = 8'h53;

  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  typedef enum logic [2:0] {
    IDLE,
    PC,
    SEL,
    RST,
    LOAD
  } state_e;

  // Width of a down-counter able to hold the longer of the two pulse lengths.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/sys_debug_host_if.sv
// Byte-wide command stream from the host link into the debug controller.
interface sys_debug_host_if;

  logic       cmd_valid;
  logic [7:0] cmd_data;
  logic       cmd_ready;

  modport master (output cmd_valid, output cmd_data, input  cmd_ready);
  modport slave  (input  cmd_valid, input  cmd_data, output cmd_ready);

endinterface

// File: rtl/dbg_pulse_gen.sv
// Loadable down-counter: pulse stays high for len cycles after start; done marks the last one.
module dbg_pulse_gen #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] len,
  output logic         pulse,
  output logic         done
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start)
      cnt_d = len;
    else if (cnt_q != '0)
      cnt_d = cnt_q - W'(1);
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values together.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign pulse = (cnt_q != '0);
  assign done  = (cnt_q == W'(1));

endmodule

// File: rtl/sys_debug_host.sv
// Debug host controller: parses 'R'/'L'/'S' commands into reset pulses, PC loads and output-select writes.
// Optional response channel (rsp_valid/rsp_data) enabled by defining SYS_DEBUG_ACK_EN.
module sys_debug_host
  import sys_debug_pkg::*;
#(
  parameter int         RST_CYCLES   = 5,
  parameter int         LOAD_CYCLES  = 2,
  parameter logic [7:0] OUTSEL_RESET = 8'd1
) (
  input  logic                clk,
  input  logic                reset,
  sys_debug_host_if.slave     cmd,
  output logic                sys_reset,
  output logic                sys_load,
  output logic [31:0]         sys_pc_load,
  output logic [7:0]          sys_output_sel,
  output logic                busy,
  output logic                err
`ifdef SYS_DEBUG_ACK_EN
  ,
  output logic                rsp_valid,
  output logic [7:0]          rsp_data
`endif
);

  localparam int CW = cnt_width(RST_CYCLES, LOAD_CYCLES);

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] hold_q, hold_d;   // first three PC bytes; the fourth goes straight to sys_pc_load
  logic [31:0] pc_q, pc_d;
  logic [7:0]  sel_q, sel_d;
  logic        err_q, err_d;
  logic        rst_start, rst_done, load_start, load_done;
  logic        accept;
`ifdef SYS_DEBUG_ACK_EN
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_data_q, rsp_data_d;
`endif

  assign accept = cmd.cmd_valid && cmd.cmd_ready;

  // NOTE: every variable gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hold_d     = hold_q;
    pc_d       = pc_q;
    sel_d      = sel_q;
    err_d      = err_q;
    rst_start  = 1'b0;
    load_start = 1'b0;
`ifdef SYS_DEBUG_ACK_EN
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
`endif
    unique case (state_q)
      IDLE: if (accept) begin
        unique case (cmd.cmd_data)
          OP_RST:  begin state_d = RST; rst_start = 1'b1; end
          OP_LOAD: begin state_d = PC;  cnt_d = 2'd0;     end
          OP_SEL:  state_d = SEL;
          default: begin
            err_d = 1'b1;
`ifdef SYS_DEBUG_ACK_EN
            rsp_valid_d = 1'b1;
            rsp_data_d  = NAK;
`endif
          end
        endcase
      end
      PC: if (accept) begin
        hold_d = {hold_q[15:0], cmd.cmd_data};
        if (cnt_q == 2'd3) begin
          pc_d       = {hold_q, cmd.cmd_data};
          load_start = 1'b1;
          state_d    = LOAD;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      SEL: if (accept) begin
        sel_d   = cmd.cmd_data;
        state_d = IDLE;
`ifdef SYS_DEBUG_ACK_EN
        rsp_valid_d = 1'b1;
        rsp_data_d  = ACK;
`endif
      end
      RST, LOAD: if ((state_q == RST) ? rst_done : load_done) begin
        state_d = IDLE;
`ifdef SYS_DEBUG_ACK_EN
        rsp_valid_d = 1'b1;
        rsp_data_d  = ACK;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      hold_q  <= '0;
      pc_q    <= '0;
      sel_q   <= OUTSEL_RESET;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      pc_q    <= pc_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
    end
  end

`ifdef SYS_DEBUG_ACK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
`endif

  dbg_pulse_gen #(.W(CW)) u_rst_pulse (
    .clk   (clk),
    .reset (reset),
    .start (rst_start),
    .len   (CW'(RST_CYCLES)),
    .pulse (sys_reset),
    .done  (rst_done)
  );

  dbg_pulse_gen #(.W(CW)) u_load_pulse (
    .clk   (clk),
    .reset (reset),
    .start (load_start),
    .len   (CW'(LOAD_CYCLES)),
    .pulse (sys_load),
    .done  (load_done)
  );

  assign cmd.cmd_ready   = (state_q == IDLE) || (state_q == PC) || (state_q == SEL);
  assign busy            = (state_q != IDLE);
  assign sys_pc_load     = pc_q;
  assign sys_output_sel  = sel_q;
  assign err             = err_q;

endmodule

// File: tb/tb_sys_debug_host.sv
// Scoreboard bench for sys_debug_host: command-level model pushes expected events, a negedge monitor checks them.
module tb_sys_debug_host;
  import sys_debug_pkg::*;

  localparam int RST_N  = 5;
  localparam int LOAD_N = 2;
  localparam int HALF   = 5;

  typedef enum int { EV_RST, EV_LOAD, EV_SEL, EV_ERR, EV_RSP } ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    time         t;
    int          w;
    logic [31:0] v;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sys_reset, sys_load, busy, err;
  logic [31:0] sys_pc_load;
  logic [7:0]  sys_output_sel;
`ifdef SYS_DEBUG_ACK_EN
  logic        rsp_valid;
  logic [7:0]  rsp_data;
`endif

  sys_debug_host_if cmd_if ();

  sys_debug_host #(.RST_CYCLES(RST_N), .LOAD_CYCLES(LOAD_N), .OUTSEL_RESET(8'd1)) dut (
    .clk            (clk),
    .reset          (reset),
    .cmd            (cmd_if),
    .sys_reset      (sys_reset),
    .sys_load       (sys_load),
    .sys_pc_load    (sys_pc_load),
    .sys_output_sel (sys_output_sel),
    .busy           (busy),
    .err            (err)
`ifdef SYS_DEBUG_ACK_EN
    ,
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data)
`endif
  );

  always #HALF clk = ~clk;

  int  n_vec = 0;
  int  n_mis = 0;
  ev_t exp_q[$];

  // Command-level model of the visible state.
  logic [7:0]  m_sel = 8'd1;
  logic        m_err = 1'b0;
  logic [31:0] m_pc  = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_mis++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_ev(input ev_kind_e k, input time t, input int w, input logic [31:0] v);
    ev_t e;
    e.kind = k; e.t = t; e.w = w; e.v = v;
    exp_q.push_back(e);
  endtask

  task automatic push_rsp(input time t, input logic [7:0] b);
`ifdef SYS_DEBUG_ACK_EN
    push_ev(EV_RSP, t, 0, {24'h0, b});
`endif
  endtask

  task automatic expect_ev(input ev_kind_e k, input time t, input int w, input logic [31:0] v);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_mis++;
      $display("FAIL unexpected_event: got kind %0d at %0t, required no event", k, t);
      return;
    end
    e = exp_q.pop_front();
    check("ev_kind", k, e.kind);
    check("ev_time", t, e.t);
    if (e.kind == EV_RST || e.kind == EV_LOAD) check("ev_width", w, e.w);
    if (e.kind != EV_RST) check("ev_value", v, e.v);
  endtask

  // Driver stays in phase "1 time unit after a rising edge".
  task automatic idle(input int g);
    cmd_if.cmd_valid = 1'b0;
    repeat (g) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b, output time t_acc);
    int n = 0;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_data  = b;
    t_acc = 0;
    while (!cmd_if.cmd_ready) begin
      @(posedge clk); #1;
      n++;
      if (n > 200) begin
        n_vec++;
        n_mis++;
        $display("FAIL ready_timeout: got cmd_ready=0 for %0d cycles, required 1", n);
        return;
      end
    end
    @(posedge clk);
    t_acc = $time;
    #1;
  endtask

  task automatic send_cmd(input int kind, input logic [31:0] arg);
    time t;
    case (kind)
      0: begin
        send_byte(OP_RST, t);
        push_ev(EV_RST, t + HALF, RST_N, 0);
        push_rsp(t + HALF + RST_N * 2 * HALF, ACK);
      end
      1: begin
        send_byte(OP_LOAD, t);
        for (int i = 3; i >= 0; i--) begin
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
          send_byte(arg[8*i +: 8], t);
        end
        push_ev(EV_LOAD, t + HALF, LOAD_N, arg);
        m_pc = arg;
        push_rsp(t + HALF + LOAD_N * 2 * HALF, ACK);
      end
      2: begin
        send_byte(OP_SEL, t);
        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        send_byte(arg[7:0], t);
        if (arg[7:0] != m_sel) push_ev(EV_SEL, t + HALF, 0, {24'h0, arg[7:0]});
        m_sel = arg[7:0];
        push_rsp(t + HALF, ACK);
      end
      default: begin
        send_byte(arg[7:0], t);
        if (!m_err) push_ev(EV_ERR, t + HALF, 0, 32'd1);
        m_err = 1'b1;
        push_rsp(t + HALF, NAK);
      end
    endcase
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_sel = 8'd1;
    m_err = 1'b0;
    m_pc  = '0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin @(posedge clk); #1; n++; end
    check("drain_pending", exp_q.size(), 0);
  endtask

  // Monitor: turns output activity into events and matches them against the queue.
  logic        prev_rst = 1'b0, prev_load = 1'b0, prev_err = 1'b0, skip = 1'b0;
  logic [31:0] prev_pc = '0, ld_val = '0;
  logic [7:0]  prev_sel = 8'd1;
  time         rst_t0 = 0, ld_t0 = 0;
  int          rst_w = 0, ld_w = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (reset || skip) begin
        skip      = reset;
        prev_rst  = sys_reset;
        prev_load = sys_load;
        prev_err  = err;
        prev_pc   = sys_pc_load;
        prev_sel  = sys_output_sel;
        continue;
      end
      check("cmd_ready_vs_pulse", cmd_if.cmd_ready, !(sys_reset || sys_load));
      if (sys_reset && !prev_rst) begin rst_t0 = $time; rst_w = 0; end
      if (sys_reset) rst_w++;
      if (!sys_reset && prev_rst) expect_ev(EV_RST, rst_t0, rst_w, 0);
      if (sys_load && !prev_load) begin ld_t0 = $time; ld_w = 0; ld_val = sys_pc_load; end
      else check("pc_load_hold", sys_pc_load, prev_pc);
      if (sys_load) ld_w++;
      if (!sys_load && prev_load) expect_ev(EV_LOAD, ld_t0, ld_w, ld_val);
      if (sys_output_sel != prev_sel) expect_ev(EV_SEL, $time, 0, {24'h0, sys_output_sel});
      if (err != prev_err) expect_ev(EV_ERR, $time, 0, {31'h0, err});
`ifdef SYS_DEBUG_ACK_EN
      if (rsp_valid) expect_ev(EV_RSP, $time, 0, {24'h0, rsp_data});
`endif
      prev_rst  = sys_reset;
      prev_load = sys_load;
      prev_err  = err;
      prev_pc   = sys_pc_load;
      prev_sel  = sys_output_sel;
    end
  end

  initial begin
    time         t;
    logic [7:0]  b;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    check("rst_sys_reset", sys_reset, 1'b0);
    check("rst_sys_load", sys_load, 1'b0);
    check("rst_pc_load", sys_pc_load, 32'h0);
    check("rst_output_sel", sys_output_sel, 8'd1);
    check("rst_err", err, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_cmd_ready", cmd_if.cmd_ready, 1'b1);
`ifdef SYS_DEBUG_ACK_EN
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_data", rsp_data, 8'h00);
`endif

    // Directed sequence from the command set's headline behaviours.
    send_cmd(0, 0);
    send_cmd(1, 32'd140);
    send_cmd(2, 32'h03);
    send_cmd(0, 0);
    send_cmd(3, 32'h41);
    send_cmd(0, 0);
    send_cmd(3, 32'h00);
    idle(1);
    drain();
    check("err_sticky", err, 1'b1);
    check("sel_after_rst", sys_output_sel, 8'd3);

    // Reset in the middle of a PC load discards the partial value.
    send_byte(OP_LOAD, t);
    send_byte(8'h12, t);
    send_byte(8'h34, t);
    idle(1);
    check("busy_in_pc", busy, 1'b1);
    pulse_reset();
    check("midrst_pc_load", sys_pc_load, 32'h0);
    check("midrst_sel", sys_output_sel, 8'd1);
    check("midrst_err", err, 1'b0);
    check("midrst_busy", busy, 1'b0);
    idle(4);
    check("midrst_no_load", sys_load, 1'b0);
    send_cmd(1, 32'h10);
    idle(1);
    drain();
    check("pc_after_midrst", sys_pc_load, 32'h10);

    // Randomised command stream, with gaps and valid held through pulses.
    for (int i = 0; i < 80; i++) begin
      int k;
      k = $urandom_range(0, 3);
      if (k == 3) begin
        do b = 8'($urandom); while (b == OP_RST || b == OP_LOAD || b == OP_SEL);
        send_cmd(3, {24'h0, b});
      end else begin
        send_cmd(k, $urandom);
      end
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 4));
    end
    idle(1);
    drain();

    check("final_sel", sys_output_sel, m_sel);
    check("final_err", err, m_err);
    check("final_pc", sys_pc_load, m_pc);
    check("final_busy", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/sys_debug_host.md
# sys_debug_host

Host-side debug controller that drives the system master's debug inputs (`reset`, `load`, `pc_load`, `output_sel`) from a byte-wide command stream. The command stream comes from a UART receiver or a bench driver. Commands are parsed by a small FSM and turned into timed reset pulses, PC-load pulses and output-select updates. The block sits between the host link and the system master, so the master can be restarted, redirected and observed without re-synthesis.

## Interface
Parameters:
- `RST_CYCLES`, 5: width in clocks of the `sys_reset` pulse; must be ≥1.
- `LOAD_CYCLES`, 2: width in clocks of the `sys_load` pulse; must be ≥1.
- `OUTSEL_RESET`, 8'd1: reset value of `sys_output_sel`.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `cmd_valid`  in  1: `cmd_data` holds a byte.
- `cmd_data`  in  8: command or argument byte.
- `cmd_ready`  out  1: the block can accept a byte.
- `sys_reset`  out  1: reset pulse to the system master.
- `sys_load`  out  1: PC-load strobe to the system master.
- `sys_pc_load`  out  32: PC value to the system master.
- `sys_output_sel`  out  8: output select to the system master.
- `busy`  out  1: the FSM is not in IDLE.
- `err`  out  1: sticky flag, set when an unknown opcode is received.

## Operation
- A byte transfers on any rising edge where `cmd_valid && cmd_ready`. `cmd_data` is ignored otherwise.
- Opcodes:
  - 0x52 'R': reset pulse. No argument bytes.
  - 0x4C 'L': PC load. Followed by 4 argument bytes, big-endian (MSB first).
  - 0x53 'S': set output select. Followed by 1 argument byte.
- Any other byte in IDLE sets `err`, and the FSM stays in IDLE.
- FSM states:
  - IDLE: `cmd_ready`=1. 'R' goes to RST. 'L' goes to PC, with the byte counter set to 0. 'S' goes to SEL.
  - PC: `cmd_ready`=1. Each accepted byte shifts into a 32-bit holding register and increments the counter. On the 4th byte, the FSM goes to LOAD and the holding value is copied to `sys_pc_load`.
  - SEL: `cmd_ready`=1. The accepted byte is written to `sys_output_sel`, and the FSM returns to IDLE.
  - RST: `cmd_ready`=0. `sys_reset`=1 for `RST_CYCLES` clocks, then the FSM returns to IDLE.
  - LOAD: `cmd_ready`=0. `sys_load`=1 for `LOAD_CYCLES` clocks, then the FSM returns to IDLE.
- Argument bytes are never decoded as opcodes; an 'R' inside a PC argument is data.
- `sys_pc_load` holds its value after LOAD ends. It changes only on completion of an 'L' command.
- `sys_output_sel` is not affected by 'R'.
- `err` stays set until `reset`.
- `busy` is 1 in every state except IDLE.

## Timing
- Reset values:
  - `sys_reset`=0, `sys_load`=0.
  - `sys_pc_load`=0, `sys_output_sel`=`OUTSEL_RESET`.
  - `err`=0, `busy`=0, state=IDLE.
  - `cmd_ready`=1 in the first cycle after `reset` deasserts.
- 'R' accepted at edge t: `sys_reset` is high from edge t+1 through edge t+`RST_CYCLES`. `cmd_ready` is 1 again after `sys_reset` falls.
- 4th 'L' byte accepted at edge t:
  - `sys_pc_load` is valid from edge t+1.
  - `sys_load` is high for edges t+1 through t+`LOAD_CYCLES`.
  - `sys_pc_load` is therefore stable for the whole strobe.
- 'S' argument accepted at edge t: `sys_output_sel` updates at edge t+1.
- Minimum command spacing:
  - 'S' takes 2 accepted bytes and no dead cycles.
  - 'R' takes 1 byte plus `RST_CYCLES` cycles with `cmd_ready`=0.
- Boundary conditions:
  - `reset` mid-command (any state) abandons the command and discards a partial PC. Outputs return to reset values on the next edge, and no pulse is emitted.
  - `cmd_valid` held high during RST or LOAD: no byte is consumed. The byte is taken in the first IDLE cycle.
  - Gaps (`cmd_valid`=0) between argument bytes are allowed and unbounded.
- The pulse counters are sized $clog2(max(`RST_CYCLES`,`LOAD_CYCLES`)+1). The byte counter is 2 bits and never wraps past 3.

## Configuration
- `SYS_DEBUG_ACK_EN` defined:
  - Adds two output ports: `rsp_valid` (1 bit) and `rsp_data` (8 bits).
  - After each completed command, the block emits exactly one response byte. 0x06 (ACK) is emitted when RST/LOAD finishes or when the SEL argument is accepted. 0x15 (NAK) is emitted for an unknown opcode.
  - `rsp_valid` is a 1-cycle pulse with no backpressure, on the edge the FSM re-enters IDLE.
  - Reset values: `rsp_valid`=0, `rsp_data`=0.
- `SYS_DEBUG_ACK_EN` undefined: these ports do not exist, and `err` is the only error indication.

## Structure
- Package `sys_debug_pkg` holds:
  - Opcode constants: OP_RST=8'h52, OP_LOAD=8'h4C, OP_SEL=8'h53.
  - Response constants: ACK=8'h06, NAK=8'h15.
  - The FSM state enum: IDLE, PC, SEL, RST, LOAD.
- One sub-module, `dbg_pulse_gen`, is instantiated twice (for `sys_reset` and `sys_load`).
  - Inputs: `clk`, `reset`, `start`, `len`.
  - Outputs: `pulse`, `done`.
  - Loadable down-counter that holds `pulse` high for `len` cycles.

## Test plan
- Default parameters:
  - Reset, then send 'R' → `sys_reset` high for exactly 5 cycles starting 1 cycle after acceptance, and `cmd_ready` low for the same 5 cycles.
  - Send 'L',00,00,00,8C → `sys_pc_load`=32'd140 one cycle after the last byte, `sys_load` high 2 cycles, and `sys_pc_load` unchanged afterward.
- Send 'S',03 → `sys_output_sel` changes 8'd1→8'd3 one cycle after the argument byte. Send 'R' → `sys_output_sel` stays 3.
- Send 0x41 → `err`=1, no pulse. Then send 'R' → normal pulse, and `err` remains 1 until `reset`.
- Send 'L',12,34 then assert `reset` for 1 cycle → no `sys_load`, `sys_pc_load`=0. Then send 'L',00,00,00,10 → `sys_pc_load`=32'h10.
- With `SYS_DEBUG_ACK_EN`: send 'R' → one `rsp_valid` pulse with 0x06 on return to IDLE. Send 0x00 → `rsp_data`=0x15.
